// File: rtl/inert_pkg.sv
// rtl/inert_pkg.sv - shared types and constants for the inertial sensor interface
package inert_pkg;

  localparam int INIT_WORDS_MAX = 4;

  // Sensor configuration frames, sent in index order after power-up.
  localparam logic [INIT_WORDS_MAX-1:0][15:0] INIT_CMDS =
    {16'h1460, 16'h1150, 16'h1053, 16'h0D02};

  localparam logic RD_BIT = 1'b1;

  typedef enum logic [2:0] {
    POR_WAIT,
    INIT_XFER,
    IDLE,
    RD_XFER,
    DONE
  } state_t;

endpackage

// File: rtl/spi_frame_mnrch.sv
// rtl/spi_frame_mnrch.sv - SPI mode-3 master, one 16-bit frame per wrt, enforced inter-frame gap
module spi_frame_mnrch #(
  parameter int SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] cmd,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam int HALF = SCLK_DIV / 2;
  localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [HW-1:0] hcnt;
  logic [HW-1:0] gap;
  logic [5:0]    half;
  logic          active;
  logic [15:0]   tx;
  logic [15:0]   rx;

  assign rd_data = rx;

  // Frame is 34 half-periods: front porch, 32 SCLK halves (odd = low), back porch.
  always_ff @(posedge clk) begin
    if (rst) begin
      SS_n   <= 1'b1;
      SCLK   <= 1'b1;
      MOSI   <= 1'b0;
      done   <= 1'b0;
      active <= 1'b0;
      hcnt   <= '0;
      half   <= '0;
      gap    <= '0;
      tx     <= '0;
      rx     <= '0;
    end else begin
      done <= 1'b0;
      if (!active) begin
        if (gap != '0) begin
          gap <= gap - HW'(1);
        end else if (wrt) begin
          active <= 1'b1;
          SS_n   <= 1'b0;
          tx     <= cmd;
          hcnt   <= '0;
          half   <= '0;
        end
      end else if (hcnt != HW'(HALF - 1)) begin
        hcnt <= hcnt + HW'(1);
      end else begin
        hcnt <= '0;
        if (half == 6'd33) begin
          active <= 1'b0;
          SS_n   <= 1'b1;
          done   <= 1'b1;
          gap    <= HW'(HALF - 1);
        end else begin
          half <= half + 6'd1;
          if (!half[0] && half <= 6'd30) begin
            SCLK <= 1'b0;
            MOSI <= tx[15];
            tx   <= {tx[14:0], 1'b0};
          end else if (half[0]) begin
            SCLK <= 1'b1;
            rx   <= {rx[14:0], MISO};
          end
        end
      end
    end
  end

endmodule

// File: rtl/inert_intf_gen.sv
// rtl/inert_intf_gen.sv - inertial sensor interface: power-up config, INT-driven atomic channel reads
module inert_intf_gen
  import inert_pkg::*;
#(
  parameter int         NUM_CH     = 3,
  parameter logic [6:0] CH_BASE    = 7'h22,
  parameter int         SCLK_DIV   = 32,
  parameter int         POR_WAIT_W = 16,
  parameter int         INIT_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  INT,
  input  logic                  MISO,
  output logic                  SS_n,
  output logic                  SCLK,
  output logic                  MOSI,
  input  logic                  clr_ovr,
  output logic [NUM_CH*16-1:0]  ch_data,
  output logic                  vld,
  output logic                  busy,
  output logic                  ovr
);

  generate
    if (int'(CH_BASE) + 2 * NUM_CH - 1 > 127) begin : g_addr_range
      $error("inert_intf_gen: channel register range exceeds 7-bit address space");
    end
    if (INIT_WORDS < 1 || INIT_WORDS > INIT_WORDS_MAX) begin : g_init_range
      $error("inert_intf_gen: INIT_WORDS out of range of INIT_CMDS");
    end
  endgenerate

  state_t                  state, state_n;
  logic [POR_WAIT_W-1:0]   por_cnt;
  logic                    int_s1, int_s2, int_s3;
  logic                    int_edge;
  logic [7:0]              idx;
  logic [NUM_CH*16-1:0]    shadow;
  logic                    pend;
  logic                    wrt;
  logic [15:0]             cmd;
  logic                    done;
  logic [15:0]             rd_data;
  logic [6:0]              rd_addr;
  logic                    unused_rd_hi;

  assign int_edge     = int_s2 & ~int_s3;
  assign busy         = (state != IDLE);
  assign wrt          = (state == INIT_XFER) || (state == RD_XFER);
  assign rd_addr      = CH_BASE + idx[6:0];
  assign unused_rd_hi = &{1'b0, rd_data[15:8]};

  always_comb begin
    cmd = {RD_BIT, rd_addr, 8'h00};
    if (state == INIT_XFER) cmd = INIT_CMDS[idx[1:0]];
  end

  spi_frame_mnrch #(.SCLK_DIV(SCLK_DIV)) u_spi (
    .clk     (clk),
    .rst     (rst),
    .wrt     (wrt),
    .cmd     (cmd),
    .done    (done),
    .rd_data (rd_data),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= POR_WAIT;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      POR_WAIT:  if (por_cnt == '1) state_n = INIT_XFER;
      INIT_XFER: if (done && idx == 8'(INIT_WORDS - 1)) state_n = IDLE;
      IDLE:      if (int_edge) state_n = RD_XFER;
      RD_XFER:   if (done && idx == 8'(2 * NUM_CH - 1)) state_n = DONE;
      DONE:      state_n = (pend || int_edge) ? RD_XFER : IDLE;
      default:   state_n = POR_WAIT;
    endcase
  end

  // Frame index returns to 0 whenever a transfer phase ends, so every phase starts at frame 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      int_s1  <= 1'b0;
      int_s2  <= 1'b0;
      int_s3  <= 1'b0;
      por_cnt <= '0;
      idx     <= '0;
      shadow  <= '0;
      ch_data <= '0;
      vld     <= 1'b0;
      pend    <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      int_s1 <= INT;
      int_s2 <= int_s1;
      int_s3 <= int_s2;
      vld    <= 1'b0;
      if (state == POR_WAIT && por_cnt != '1) por_cnt <= por_cnt + POR_WAIT_W'(1);
      if (done) begin
        if (state == RD_XFER) shadow[idx*8 +: 8] <= rd_data[7:0];
        idx <= (state_n != state) ? 8'd0 : idx + 8'd1;
      end
      if (state == DONE) begin
        ch_data <= shadow;
        vld     <= 1'b1;
        pend    <= 1'b0;
      end
      if (clr_ovr) ovr <= 1'b0;
      if (int_edge && (state == RD_XFER || state == DONE)) begin
        ovr <= 1'b1;
        if (state == RD_XFER) pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inert_intf_gen.sv
// tb/tb_inert_intf_gen.sv - directed bench for inert_intf_gen with a register-echo sensor model
module tb_inert_intf_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        INT = 1'b0;
  logic        MISO = 1'b0;
  logic        clr_ovr = 1'b0;
  logic        SS_n, SCLK, MOSI, vld, busy, ovr;
  logic [47:0] ch_data;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] init_exp [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
  logic [15:0] rd_exp   [6] = '{16'hA200, 16'hA300, 16'hA400, 16'hA500, 16'hA600, 16'hA700};
  logic [47:0] ch_exp = {16'hF2F3, 16'hF0F1, 16'hF6F7};

  always #5 clk = ~clk;

  inert_intf_gen #(
    .NUM_CH(3), .CH_BASE(7'h22), .SCLK_DIV(32), .POR_WAIT_W(4), .INIT_WORDS(4)
  ) dut (
    .clk(clk), .rst(rst), .INT(INT), .MISO(MISO), .SS_n(SS_n), .SCLK(SCLK),
    .MOSI(MOSI), .clr_ovr(clr_ovr), .ch_data(ch_data), .vld(vld), .busy(busy), .ovr(ovr)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sensor: answers a read with (command high byte ^ 0x55) in the data byte.
  logic [15:0] mosi_sh = '0;
  logic [7:0]  resp = '0;
  int          nrise = 0;
  int          nfall = 0;
  logic [15:0] frames [$];

  always @(negedge SS_n) begin
    nrise = 0;
    nfall = 0;
  end

  always @(posedge SCLK) if (SS_n === 1'b0) begin
    mosi_sh = {mosi_sh[14:0], MOSI};
    if (nrise == 7) resp = mosi_sh[7:0] ^ 8'h55;
    nrise++;
  end

  always @(negedge SCLK) if (SS_n === 1'b0) begin
    MISO = (nfall >= 8 && nfall <= 15) ? resp[15-nfall] : 1'b0;
    nfall++;
  end

  always @(posedge SS_n) if (nrise == 16) frames.push_back(mosi_sh);

  int   cyc = 0, last_rise = -1, mosi_chg = 0, ss_rise = 0;
  int   min_per = 1000000, max_per = 0, min_setup = 1000000, min_gap = 1000000;
  int   vld_hi = 0, vld_pulses = 0;
  logic sclk_q = 1'b1, mosi_q = 1'b0, ss_q = 1'b1, vld_q = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      last_rise = -1;
      ss_rise   = cyc;
      mosi_chg  = cyc;
    end else begin
      if (MOSI !== mosi_q) mosi_chg = cyc;
      if (SCLK === 1'b1 && sclk_q === 1'b0 && SS_n === 1'b0) begin
        if (last_rise >= 0) begin
          if (cyc - last_rise < min_per) min_per = cyc - last_rise;
          if (cyc - last_rise > max_per) max_per = cyc - last_rise;
        end
        last_rise = cyc;
        if (cyc - mosi_chg < min_setup) min_setup = cyc - mosi_chg;
      end
      if (SS_n === 1'b1 && ss_q === 1'b0) ss_rise = cyc;
      if (SS_n === 1'b0 && ss_q === 1'b1) begin
        if (cyc - ss_rise < min_gap) min_gap = cyc - ss_rise;
        last_rise = -1;
      end
    end
    sclk_q = SCLK;
    mosi_q = MOSI;
    ss_q   = SS_n;
    if (vld === 1'b1) vld_hi++;
    if (vld === 1'b1 && vld_q !== 1'b1) vld_pulses++;
    vld_q = vld;
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frames(input int cnt, input int bound, input string tag);
    for (int i = 0; i < bound && frames.size() < cnt; i++) @(negedge clk);
    chk(tag, frames.size() >= cnt, 1'b1);
  endtask

  task automatic wait_vld(input int cnt, input int bound, input string tag);
    for (int i = 0; i < bound && vld_pulses < cnt; i++) @(negedge clk);
    chk(tag, vld_pulses >= cnt, 1'b1);
  endtask

  task automatic wait_idle(input int bound, input string tag);
    for (int i = 0; i < bound && busy !== 1'b0; i++) @(negedge clk);
    chk(tag, busy, 1'b0);
  endtask

  task automatic pulse_int(input int n);
    INT = 1'b1;
    clks(n);
    INT = 1'b0;
  endtask

  task automatic check_init(input string pfx);
    wait_frames(4, 4000, {pfx, "_frames_timeout"});
    wait_idle(400, {pfx, "_idle"});
    chk({pfx, "_count"}, frames.size(), 4);
    for (int i = 0; i < 4 && i < frames.size(); i++)
      chk($sformatf("%s_cmd%0d", pfx, i), frames[i], init_exp[i]);
  endtask

  task automatic check_reads(input string pfx, input int nseq);
    chk({pfx, "_count"}, frames.size(), 6 * nseq);
    for (int i = 0; i < 6 * nseq && i < frames.size(); i++)
      chk($sformatf("%s_cmd%0d", pfx, i), frames[i], rd_exp[i % 6]);
    chk({pfx, "_ch_data"}, ch_data, ch_exp);
  endtask

  task automatic clear_logs();
    frames.delete();
    vld_pulses = 0;
    vld_hi = 0;
  endtask

  initial begin
    // Reset state and init sequence
    clks(3);
    chk("rst_ss_n", SS_n, 1'b1);
    chk("rst_sclk", SCLK, 1'b1);
    chk("rst_mosi", MOSI, 1'b0);
    chk("rst_vld", vld, 1'b0);
    chk("rst_ch_data", ch_data, 48'h0);
    chk("rst_ovr", ovr, 1'b0);
    chk("rst_busy", busy, 1'b1);
    rst = 1'b0;
    clear_logs();
    check_init("init");

    // Single INT pulse
    clear_logs();
    pulse_int(3);
    wait_vld(1, 5000, "rd_vld_timeout");
    clks(20);
    check_reads("rd", 1);
    chk("rd_vld_pulses", vld_pulses, 1);
    chk("rd_vld_width", vld_hi, 1);
    chk("rd_ovr", ovr, 1'b0);
    chk("rd_busy", busy, 1'b0);

    // INT held high: one request only
    clear_logs();
    pulse_int(5000);
    clks(20);
    check_reads("hold", 1);
    chk("hold_vld_pulses", vld_pulses, 1);
    chk("hold_ovr", ovr, 1'b0);

    // Second edge during frame 2 sets ovr and queues one more sequence
    clear_logs();
    pulse_int(3);
    wait_frames(1, 1000, "ovr_frame1_timeout");
    clks(50);
    pulse_int(3);
    wait_vld(2, 9000, "ovr_vld_timeout");
    wait_idle(400, "ovr_idle");
    clks(5);
    check_reads("ovr", 2);
    chk("ovr_vld_pulses", vld_pulses, 2);
    chk("ovr_set", ovr, 1'b1);
    clr_ovr = 1'b1;
    clks(1);
    clr_ovr = 1'b0;
    chk("ovr_cleared", ovr, 1'b0);

    // Reset in the middle of a read frame
    clear_logs();
    pulse_int(3);
    wait_frames(1, 1000, "mid_frame1_timeout");
    pulse_int(3);
    clks(10);
    chk("mid_ovr_pre", ovr, 1'b1);
    for (int i = 0; i < 2000 && !(SS_n === 1'b0 && nrise == 8); i++) @(negedge clk);
    chk("mid_bit7_reached", (SS_n === 1'b0 && nrise == 8), 1'b1);
    rst = 1'b1;
    clks(1);
    chk("mid_rst_ss_n", SS_n, 1'b1);
    chk("mid_rst_sclk", SCLK, 1'b1);
    chk("mid_rst_ch_data", ch_data, 48'h0);
    chk("mid_rst_ovr", ovr, 1'b0);
    clks(2);
    rst = 1'b0;
    clear_logs();
    check_init("reinit");
    chk("reinit_no_vld", vld_pulses, 0);

    // SPI timing collected over the whole run
    chk("sclk_period_min", min_per, 32);
    chk("sclk_period_max", max_per, 32);
    chk("mosi_setup_15", min_setup >= 15, 1'b1);
    chk("ss_gap_16", min_gap >= 16, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
